// File: rtl/divide_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// divide_ramp_ctrl
//   Ramp controller for the divide_in ratio of the integer clock divider
//   directly downstream. A command (target ratio, step size, dwell time) is
//   taken over a valid/ready port. The ratio then walks toward the target in
//   bounded steps. Each value is held long enough for the divider to pick it
//   up at a period boundary and then run one full period. This keeps clkout
//   free of large instantaneous frequency jumps.
//
// Ports
//   i_clk          system clock, all logic on posedge
//   i_rst_n        asynchronous active-low reset
//   i_cfg_valid    command valid
//   o_cfg_ready    command accepted when valid & ready at posedge (IDLE only)
//   i_cfg_target   target ratio
//   i_cfg_step     max ratio change per step (0 behaves as 1)
//   i_cfg_dwell    minimum cycles each ratio is held
//   i_abort        stop the ramp, keep the current ratio
//   o_divide_out   registered ratio driving the divider
//   o_busy         high while stepping or dwelling
//   o_done         one-cycle pulse once the target has been held for its dwell
// ---------------------------------------------------------------------------
module divide_ramp_ctrl #(
  parameter int             W        = 8,
  parameter int             DWELL_W  = 16,
  parameter logic [W-1:0]   INIT_DIV = {W{1'b0}}
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [W-1:0]       i_cfg_target,
  input  logic [W-1:0]       i_cfg_step,
  input  logic [DWELL_W-1:0] i_cfg_dwell,
  input  logic               i_abort,
  output logic [W-1:0]       o_divide_out,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] CNT_TWO  = {{(DWELL_W-2){1'b0}}, 2'd2};
  localparam logic [W-1:0]       STEP_ONE = {{(W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [W-1:0]       r_target;
  logic [W-1:0]       r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;

  logic [W:0]         w_diff_up;
  logic [W:0]         w_diff_dn;
  logic [W-1:0]       w_next_div;
  logic [DWELL_W-1:0] w_dwell_min;
  logic [DWELL_W-1:0] w_dwell_eff;

  // Command port is ready exactly while idle.
  always_comb begin
    o_cfg_ready = 1'b0;
    if (r_state == ST_IDLE) begin
      o_cfg_ready = 1'b1;
    end else begin
      o_cfg_ready = 1'b0;
    end
  end

  // Next ratio toward the target and the dwell it must be held for.
  always_comb begin
    // Differences carry one extra bit so neither direction can wrap.
    w_diff_up  = {1'b0, r_target} - {1'b0, o_divide_out};
    w_diff_dn  = {1'b0, o_divide_out} - {1'b0, r_target};
    w_next_div = r_target;
    if (r_target > o_divide_out) begin
      if (w_diff_up <= {1'b0, r_step}) begin
        w_next_div = r_target;
      end else begin
        w_next_div = o_divide_out + r_step;
      end
    end else if (r_target < o_divide_out) begin
      if (w_diff_dn <= {1'b0, r_step}) begin
        w_next_div = r_target;
      end else begin
        w_next_div = o_divide_out - r_step;
      end
    end else begin
      w_next_div = r_target;
    end
    // Worst case for the divider to adopt a ratio d at a period boundary and
    // then complete one full period is 2*d+2 clocks.
    w_dwell_min = {{(DWELL_W-W-1){1'b0}}, w_next_div, 1'b0} + CNT_TWO;
    if (r_dwell > w_dwell_min) begin
      w_dwell_eff = r_dwell;
    end else begin
      w_dwell_eff = w_dwell_min;
    end
  end

  // Ramp FSM with registered ratio, busy and done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_target     <= {W{1'b0}};
      r_step       <= {W{1'b0}};
      r_dwell      <= {DWELL_W{1'b0}};
      r_cnt        <= {DWELL_W{1'b0}};
      o_divide_out <= INIT_DIV;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Abort is ignored here; a same-edge command is still taken.
          if (i_cfg_valid) begin
            r_target <= i_cfg_target;
            if (i_cfg_step == {W{1'b0}}) begin
              r_step <= STEP_ONE;
            end else begin
              r_step <= i_cfg_step;
            end
            r_dwell <= i_cfg_dwell;
            r_state <= ST_STEP;
            o_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_STEP: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end else begin
            o_divide_out <= w_next_div;
            r_cnt        <= w_dwell_eff;
            r_state      <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            o_busy  <= 1'b0;
          end else if (r_cnt == CNT_ONE) begin
            if (o_divide_out != r_target) begin
              r_state <= ST_STEP;
            end else begin
              r_state <= ST_IDLE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divide_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_divide_ramp_ctrl
//   Self-checking bench for divide_ramp_ctrl. For every command the expected
//   ratio schedule (update edges, values, done edge) is worked out up front
//   from the ramp rules with plain integer arithmetic. All outputs are then
//   compared on every cycle, one time unit after the active edge.
// ---------------------------------------------------------------------------
module tb_divide_ramp_ctrl;

  localparam int W  = 8;
  localparam int DW = 16;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          cfg_valid  = 1'b0;
  logic          abort      = 1'b0;
  logic [W-1:0]  cfg_target = '0;
  logic [W-1:0]  cfg_step   = '0;
  logic [DW-1:0] cfg_dwell  = '0;
  logic          cfg_ready;
  logic          busy;
  logic          done;
  logic [W-1:0]  divide_out;

  int n_err = 0;
  int n_chk = 0;
  int cur   = 0;     // ratio the DUT should hold when idle
  int ut[$];         // edge offsets (from accept edge) of ratio updates
  int uv[$];         // ratio value written at each of those edges

  divide_ramp_ctrl #(.W(W), .DWELL_W(DW), .INIT_DIV(8'd0)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_target (cfg_target),
    .i_cfg_step   (cfg_step),
    .i_cfg_dwell  (cfg_dwell),
    .i_abort      (abort),
    .o_divide_out (divide_out),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input int e_div, input int e_busy, input int e_done, input int e_rdy);
    check("divide_out", int'(divide_out), e_div);
    check("busy",       int'(busy),       e_busy);
    check("done",       int'(done),       e_done);
    check("cfg_ready",  int'(cfg_ready),  e_rdy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One ramp step: move toward tgt by at most st, never overshooting.
  function automatic int next_ratio(input int d, input int tgt, input int st);
    if (tgt > d) return (tgt - d <= st) ? tgt : d + st;
    if (tgt < d) return (d - tgt <= st) ? tgt : d - st;
    return d;
  endfunction

  // Ratio expected after edge k of the current command.
  function automatic int exp_div(input int k);
    int v = cur;
    foreach (ut[i]) if (ut[i] <= k) v = uv[i];
    return v;
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_outs(cur, 0, 0, 1);
    end
  endtask

  // Issue one command and follow it edge by edge.
  //   abort_at : edge offset after which abort is raised (-1 none, -2 random)
  //   rst_at   : edge offset after which rst_n is pulsed (-1 none)
  //   ab0      : raise abort together with the command (must be ignored)
  //   hold     : keep cfg_valid high with tgt2 while busy and afterwards
  task automatic run_cmd(input int tgt, input int st, input int dw, input int abort_at,
                         input int rst_at, input bit ab0, input bit hold, input int tgt2);
    int sv;
    int dd;
    int t;
    int de;
    int done_e;
    sv = (st == 0) ? 1 : st;
    ut.delete();
    uv.delete();
    dd = cur;
    t  = 1;
    done_e = 0;
    forever begin
      dd = next_ratio(dd, tgt, sv);
      ut.push_back(t);
      uv.push_back(dd);
      de = (dw > 2 * dd + 2) ? dw : 2 * dd + 2;
      if (dd == tgt) begin
        done_e = t + de;
        break;
      end
      t = t + de + 1;
    end
    if (abort_at == -2) abort_at = $urandom_range(0, done_e - 1);

    check("ready_pre", int'(cfg_ready), 1);
    cfg_valid  = 1'b1;
    cfg_target = tgt[W-1:0];
    cfg_step   = st[W-1:0];
    cfg_dwell  = dw[DW-1:0];
    abort      = ab0;
    tick();
    abort = 1'b0;
    for (int k = 0; k <= done_e; k++) begin
      check_outs(exp_div(k), (k < done_e) ? 1 : 0, (k == done_e) ? 1 : 0, (k >= done_e) ? 1 : 0);
      if (k == abort_at) begin
        cfg_valid = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        check_outs(exp_div(k), 0, 0, 1);
        cur = exp_div(k);
        idle_check(3);
        return;
      end
      if (k == rst_at) begin
        cfg_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_outs(0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cur   = 0;
        idle_check(2);
        return;
      end
      if (k == done_e) break;
      if (hold) begin
        cfg_valid  = 1'b1;
        cfg_target = tgt2[W-1:0];
      end else begin
        // Commands offered while busy must be ignored.
        cfg_valid  = 1'($urandom_range(0, 1));
        cfg_target = 8'($urandom_range(0, 255));
      end
      tick();
    end
    cur = tgt;
    if (!hold) begin
      cfg_valid = 1'b0;
      idle_check(2);
    end
  endtask

  initial begin
    // Reset state, asynchronous, before the first edge.
    #2;
    check_outs(0, 0, 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Ten idle cycles with no command.
    idle_check(10);

    // Up-ramp 0 -> 10, step 4, dwell 5; abort offered with the command.
    run_cmd(10, 4, 5, -1, -1, 1'b1, 1'b0, 0);
    // Reach 200 in one step, then step-of-1 down-ramp to 197.
    run_cmd(200, 255, 0, -1, -1, 1'b0, 1'b0, 0);
    run_cmd(197, 0, 3, -1, -1, 1'b0, 1'b0, 0);
    // Back to 0, then abort during the first dwell of the up-ramp.
    run_cmd(0, 255, 0, -1, -1, 1'b0, 1'b0, 0);
    run_cmd(10, 4, 5, 5, -1, 1'b0, 1'b0, 0);
    run_cmd(7, 2, 3, -1, -1, 1'b0, 1'b0, 0);
    // Abort in the STEP cycle right after accept: no update at all.
    run_cmd(30, 5, 4, 0, -1, 1'b0, 1'b0, 0);
    // cfg_valid held with a different target while busy.
    run_cmd(20, 8, 2, -1, -1, 1'b0, 1'b1, 5);
    run_cmd(5, 3, 1, -1, -1, 1'b0, 1'b0, 0);
    // Reset mid-dwell at ratio 8, then target equal to current ratio.
    run_cmd(0, 255, 0, -1, -1, 1'b0, 1'b0, 0);
    run_cmd(10, 4, 5, -1, 15, 1'b0, 1'b0, 0);
    run_cmd(0, 4, 5, -1, -1, 1'b0, 1'b0, 0);
    run_cmd(9, 9, 40, -1, -1, 1'b0, 1'b0, 0);
    run_cmd(9, 3, 2, -1, -1, 1'b0, 1'b0, 0);

    // Randomized commands, some aborted at a random point.
    for (int i = 0; i < 6; i++) begin
      run_cmd($urandom_range(0, 63), $urandom_range(0, 16), $urandom_range(0, 100),
              ($urandom_range(0, 2) == 0) ? -2 : -1, -1, 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
